// File: rtl/mcycle_pkg.sv
// Shared constants and step counts for the multi-cycle multiply/divide controller and datapath.
package mcycle_pkg;

  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

  function automatic int mul_steps(input int w);
    return w;
  endfunction

  // Divide spends one extra step on divisor setup before the restoring iterations.
  function automatic int div_steps(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mcycle_addsub.sv
// Shared adder/subtractor: combinational, zero latency, no flow control.
// o_cout is the carry out when adding and the borrow (a < b) when subtracting.
module mcycle_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y,
  output logic         o_cout
);

  logic [W:0] w_res;

  assign w_res = i_sub ? ({1'b0, i_a} - {1'b0, i_b})
                       : ({1'b0, i_a} + {1'b0, i_b});
  assign {o_cout, o_y} = w_res;

endmodule

// File: rtl/mcycle_datapath.sv
// Shift-add multiply / restoring divide datapath stepped by an external controller.
// Control is combinational from state; results and Valid appear the cycle after the last step.
module mcycle_datapath
  import mcycle_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             MCycleOp,
  input  logic [width-1:0] Operand1,
  input  logic [width-1:0] Operand2,
  input  logic             Init,
  input  logic             Shift,
  input  logic             Write,
  output logic             Control,
  output logic [width-1:0] Result1,
  output logic [width-1:0] Result2,
  output logic             Valid,
  output logic             DivByZero
);

  localparam int CW = $clog2(div_steps(width) + 1);

  logic             r_op;
  logic [width-1:0] r_hi;
  logic [width-1:0] r_lo;
  logic [width-1:0] r_opb;
  logic [CW-1:0]    r_cnt;
  logic [width-1:0] r_result1;
  logic [width-1:0] r_result2;
  logic             r_valid;
  logic             r_dbz;

  logic [CW-1:0]    w_steps;
  logic             w_active;
  logic             w_last;
  logic [width:0]   w_a;
  logic [width:0]   w_y;
  logic             w_borrow;
  logic [width:0]   w_sum;
  logic [width-1:0] w_nxt_hi;
  logic [width-1:0] w_nxt_lo;

  assign w_steps  = (r_op == MCYCLE_DIV) ? CW'(div_steps(width)) : CW'(mul_steps(width));
  assign w_active = Shift && (r_cnt < w_steps);
  assign w_last   = w_active && (r_cnt == w_steps - CW'(1));

  // Multiply adds the multiplicand to hi; divide compares/subtracts on {rem, next quotient bit}.
  assign w_a = (r_op == MCYCLE_DIV) ? {r_hi, r_lo[width-1]} : {1'b0, r_hi};

  mcycle_addsub #(.W(width + 1)) u_addsub (
    .i_a    (w_a),
    .i_b    ({1'b0, r_opb}),
    .i_sub  (r_op),
    .o_y    (w_y),
    .o_cout (w_borrow)
  );

  assign w_sum = Write ? w_y : w_a;

  always_comb begin
    w_nxt_hi = r_hi;
    w_nxt_lo = r_lo;
    if (r_op == MCYCLE_MUL) begin
      w_nxt_hi = w_sum[width:1];
      w_nxt_lo = {w_sum[0], r_lo[width-1:1]};
    end else if (r_cnt != '0) begin
      w_nxt_hi = w_sum[width-1:0];
      w_nxt_lo = {r_lo[width-2:0], Write};
    end
  end

  assign Control   = (r_op == MCYCLE_MUL) ? r_lo[0] : ((r_cnt != '0) && !w_borrow);
  assign Result1   = r_result1;
  assign Result2   = r_result2;
  assign Valid     = r_valid;
  assign DivByZero = r_dbz;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_op      <= MCYCLE_MUL;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_valid   <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (Init) begin
        r_op  <= MCycleOp;
        r_hi  <= '0;
        r_cnt <= '0;
        r_dbz <= 1'b0;
        if (MCycleOp == MCYCLE_DIV) begin
          r_lo  <= Operand1;
          r_opb <= Operand2;
        end else begin
          r_lo  <= Operand2;
          r_opb <= Operand1;
        end
      end else if (w_active) begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= w_nxt_hi;
        r_lo  <= w_nxt_lo;
        if ((r_op == MCYCLE_DIV) && (r_cnt == '0))
          r_dbz <= (r_opb == '0);
        if (w_last) begin
          r_result1 <= w_nxt_lo;
          r_result2 <= w_nxt_hi;
          r_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_datapath.sv
// Directed bench for mcycle_datapath: multiply, divide, divide-by-zero, reset and restart cases.
module tb_mcycle_datapath;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MCycleOp = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic        Init = 1'b0;
  logic        Shift = 1'b0;
  logic        Write = 1'b0;
  logic        Control;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Valid;
  logic        DivByZero;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  mcycle_datapath #(.width(32)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .MCycleOp  (MCycleOp),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Init      (Init),
    .Shift     (Shift),
    .Write     (Write),
    .Control   (Control),
    .Result1   (Result1),
    .Result2   (Result2),
    .Valid     (Valid),
    .DivByZero (DivByZero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic op, input logic [31:0] a, input logic [31:0] b, input logic sh);
    @(negedge CLK);
    Init = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b; Shift = sh; Write = 1'b0;
    @(negedge CLK);
    Init = 1'b0; Shift = 1'b0; Write = 1'b0;
  endtask

  // Runs n Shift cycles with Write following Control, as the controller would.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge CLK);
      if (Valid === 1'b1) vcount++;
      Shift = 1'b1;
      Write = Control;
    end
    @(negedge CLK);
    if (Valid === 1'b1) vcount++;
    Shift = 1'b0;
    Write = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_result1", Result1, 0);
    chk("rst_result2", Result2, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_control", Control, 0);
    @(negedge CLK);
    Reset = 1'b1;

    // 7 x 6
    do_init(1'b0, 32'd7, 32'd6, 1'b0);
    chk("mul7x6_control_init", Control, 0);
    vcount = 0;
    run(31);
    chk("mul7x6_no_valid_early", vcount, 0);
    run(1);
    chk("mul7x6_valid_count", vcount, 1);
    chk("mul7x6_result1", Result1, 42);
    chk("mul7x6_result2", Result2, 0);
    @(negedge CLK);
    chk("mul7x6_valid_drop", Valid, 0);
    run(5);
    chk("mul7x6_saturate_valid", vcount, 1);
    chk("mul7x6_saturate_result1", Result1, 42);

    // all-ones squared
    do_init(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_ff_result_hold", Result1, 42);
    run(32);
    chk("mul_ff_result2", Result2, 32'hFFFF_FFFE);
    chk("mul_ff_result1", Result1, 32'h0000_0001);

    // 100 / 7
    do_init(1'b1, 32'd100, 32'd7, 1'b0);
    chk("div100_control_setup", Control, 0);
    vcount = 0;
    run(32);
    chk("div100_no_valid_early", vcount, 0);
    run(1);
    chk("div100_valid_count", vcount, 1);
    chk("div100_result1", Result1, 14);
    chk("div100_result2", Result2, 2);
    chk("div100_dbz", DivByZero, 0);

    // 5 / 0
    do_init(1'b1, 32'd5, 32'd0, 1'b0);
    run(1);
    chk("div0_dbz_after_setup", DivByZero, 1);
    run(32);
    chk("div0_result1", Result1, 32'hFFFF_FFFF);
    chk("div0_result2", Result2, 5);
    run(3);
    chk("div0_dbz_held", DivByZero, 1);

    // reset at step 10 of a multiply
    do_init(1'b0, 32'h1234_5678, 32'h0000_0F0F, 1'b0);
    chk("dbz_cleared_by_init", DivByZero, 0);
    run(10);
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_result1", Result1, 0);
    chk("midrst_result2", Result2, 0);
    chk("midrst_valid", Valid, 0);
    chk("midrst_control", Control, 0);
    @(negedge CLK);
    Reset = 1'b1;
    do_init(1'b0, 32'd3, 32'd3, 1'b0);
    chk("mul3x3_control_init", Control, 1);
    vcount = 0;
    run(32);
    chk("mul3x3_result1", Result1, 9);
    chk("mul3x3_result2", Result2, 0);
    chk("mul3x3_valid_count", vcount, 1);

    // divide restarted at step 5, Init issued together with Shift
    do_init(1'b1, 32'd200, 32'd9, 1'b0);
    vcount = 0;
    run(5);
    do_init(1'b1, 32'd1000, 32'd7, 1'b1);
    run(40);
    chk("restart_valid_count", vcount, 1);
    chk("restart_result1", Result1, 142);
    chk("restart_result2", Result2, 6);
    chk("restart_dbz", DivByZero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
